// File: rtl/mem_pkg.sv
// Shared types and constants for the block memory responder.
// The jitter constants are only used when MEM_JITTER_EN is defined.
package mem_pkg;

    localparam int BLOCK_W    = 128;
    localparam int MEM_ADDR_W = 28;
    localparam int LAT_W      = 9;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Feedback taps for x^8+x^6+x^5+x^4+1 on a left-shifting register
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    function automatic logic lfsr_feedback(input logic [7:0] state);
        return ^(state & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/mem_lat_gen.sv
// Latency counter for the block memory responder; done_o marks the cycle that moves to RESP.
// With MEM_JITTER_EN defined, a free-running LFSR adds 0..3 cycles per transaction.
module mem_lat_gen
    import mem_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic done_o
);

    logic [LAT_W-1:0] count_q;
    logic [LAT_W-1:0] count_d;
    logic [LAT_W-1:0] load_val_s;

`ifdef MEM_JITTER_EN
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Free-running pseudo-random source
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_feedback(lfsr_q)};
    end

    // LFSR register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign load_val_s = LAT_W'(LATENCY - 1) + {{(LAT_W-2){1'b0}}, lfsr_q[1:0]};
`else
    assign load_val_s = LAT_W'(LATENCY - 1);
`endif

    // A zero load means the response is due on the very next cycle
    always_comb begin
        count_d = count_q;
        done_o  = 1'b0;
        if (load_i) begin
            count_d = load_val_s;
            done_o  = (load_val_s == {LAT_W{1'b0}});
        end else if (count_q != {LAT_W{1'b0}}) begin
            count_d = count_q - {{(LAT_W-1){1'b0}}, 1'b1};
            done_o  = (count_q == {{(LAT_W-1){1'b0}}, 1'b1});
        end else begin
            count_d = count_q;
            done_o  = 1'b0;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {LAT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/block_mem_responder.sv
// Slow block memory answering the cache mem_read/mem_write/mem_ready handshake.
// Define MEM_JITTER_EN to add 0..3 pseudo-random cycles of latency per transaction.
module block_mem_responder
    import mem_pkg::*;
#(
    parameter int LATENCY    = 4,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic [BLOCK_W-1:0]    mem_wdata,
    output logic [BLOCK_W-1:0]    mem_rdata,
    output logic                  mem_ready,
    output logic                  mem_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    mem_state_e              state_q, state_d;
    logic                    wr_q, wr_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic [BLOCK_W-1:0]      wdata_q, wdata_d;
    logic [BLOCK_W-1:0]      rdata_q, rdata_d;
    logic                    ready_q, ready_d;
    logic                    err_q, err_d;
    logic                    load_s;
    logic                    done_s;
    logic                    req_s;
    logic [BLOCK_W-1:0]      mem_q [DEPTH];

    // Upper address bits alias onto the same block by design
    logic unused_addr_s;
    assign unused_addr_s = ^mem_addr[MEM_ADDR_W-1:DEPTH_LOG2];

    assign req_s = mem_read | mem_write;

    mem_lat_gen #(
        .LATENCY (LATENCY)
    ) u_lat_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load_s),
        .done_o (done_s)
    );

    // Next-state, capture and registered-output logic
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        load_s  = 1'b0;
        rdata_d = {BLOCK_W{1'b0}};
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    load_s  = 1'b1;
                    wr_d    = mem_write;
                    idx_d   = mem_addr[DEPTH_LOG2-1:0];
                    wdata_d = mem_wdata;
                    err_d   = err_q | (mem_read & mem_write);
                    state_d = done_s ? RESP : BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (done_s) begin
                    state_d = RESP;
                end else begin
                    state_d = BUSY;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Outputs are decoded from the next state so they come straight from flops
        ready_d = (state_d == RESP);
        if (ready_d && !wr_d) begin
            rdata_d = mem_q[idx_d];
        end else begin
            rdata_d = {BLOCK_W{1'b0}};
        end
    end

    // Control and capture registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            idx_q   <= {DEPTH_LOG2{1'b0}};
            wdata_q <= {BLOCK_W{1'b0}};
            rdata_q <= {BLOCK_W{1'b0}};
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Block storage; a reset forces IDLE, so an abandoned write never commits
    always_ff @(posedge clk) begin
        if ((state_q == RESP) && wr_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;
    assign mem_err   = err_q;

endmodule

// File: tb/tb_block_mem_responder.sv
// Scoreboard bench for block_mem_responder; expected responses queue at request time.
module tb_block_mem_responder;

    localparam int LATENCY    = 4;
    localparam int DEPTH_LOG2 = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic         mem_err;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [127:0] exp_q [$];
    logic [127:0] model_mem [int];
    bit   [3:0]   jit_seen = 4'b0000;

    block_mem_responder #(
        .LATENCY    (LATENCY),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .mem_err   (mem_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on each ready pulse, else rdata must be zero
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_ready", 128'd1, 128'd0);
                end else begin
                    check_eq("rdata", mem_rdata, exp_q.pop_front());
                end
            end else begin
                check_eq("rdata_zero_idle", mem_rdata, 128'd0);
            end
        end
    end

    // Called at a negedge; returns at the negedge of the idle cycle after the response
    task automatic txn(input logic rd, input logic wr, input logic [27:0] addr,
                       input logic [127:0] wdata, output int lat);
        int idx;
        bit done;
        idx  = int'(addr[DEPTH_LOG2-1:0]);
        done = 1'b0;
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = addr;
        mem_wdata = wdata;
        if (wr) begin
            exp_q.push_back(128'd0);
            model_mem[idx] = wdata;
        end else begin
            exp_q.push_back(model_mem.exists(idx) ? model_mem[idx] : 128'hx);
        end
        lat = 0;
        while (!done && lat < 300) begin
            @(negedge clk);
            lat++;
            if (mem_ready) done = 1'b1;
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        check_eq("ready_seen", 128'(done), 128'd1);
`ifdef MEM_JITTER_EN
        check_eq("latency_range", 128'((lat >= LATENCY) && (lat <= LATENCY + 3)), 128'd1);
        if ((lat >= LATENCY) && (lat <= LATENCY + 3)) jit_seen[lat - LATENCY] = 1'b1;
`else
        check_eq("latency", 128'(lat), 128'(LATENCY));
`endif
        @(negedge clk);
        check_eq("ready_one_cycle", 128'(mem_ready), 128'd0);
    endtask

    initial begin
        int lat;
        logic [127:0] blk;
        logic [27:0]  a;
        rst_n     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = 28'h0;
        mem_wdata = 128'h0;
        #1;
        check_eq("reset_ready", 128'(mem_ready), 128'd0);
        check_eq("reset_rdata", mem_rdata, 128'd0);
        check_eq("reset_err", 128'(mem_err), 128'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        blk = 128'h0000DEAD_00000003_00000002_00000001;
        txn(1'b0, 1'b1, 28'h10, blk, lat);
        txn(1'b1, 1'b0, 28'h10, 128'h0, lat);

        // Back-to-back write then aliased read with one idle turnaround
        txn(1'b0, 1'b1, 28'h10, 128'hCAFEF00D_11112222_33334444_55556666, lat);
        txn(1'b1, 1'b0, 28'h110, 128'h0, lat);

        for (int i = 0; i < 6; i++) begin
            a   = 28'($urandom_range(0, 28'h0FFFFFF));
            blk = {$urandom, $urandom, $urandom, $urandom};
            txn(1'b0, 1'b1, a, blk, lat);
            txn(1'b1, 1'b0, a ^ 28'h0000100, 128'h0, lat);
        end

        // Conflicting request is a write and raises the sticky error
        check_eq("err_before_conflict", 128'(mem_err), 128'd0);
        txn(1'b1, 1'b1, 28'h5, 128'h55AA55AA_00000005_00000005_00000005, lat);
        check_eq("err_set", 128'(mem_err), 128'd1);
        txn(1'b1, 1'b0, 28'h5, 128'h0, lat);
        check_eq("err_sticky", 128'(mem_err), 128'd1);

        // Reset during a write's BUSY phase must abandon the write
        txn(1'b0, 1'b1, 28'h7, 128'h1, lat);
        mem_write = 1'b1;
        mem_addr  = 28'h7;
        mem_wdata = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;
        @(negedge clk);
        @(negedge clk);
        mem_write = 1'b0;
        rst_n     = 1'b0;
        #1;
        check_eq("midreset_ready", 128'(mem_ready), 128'd0);
        check_eq("midreset_rdata", mem_rdata, 128'd0);
        check_eq("midreset_err", 128'(mem_err), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        txn(1'b1, 1'b0, 28'h7, 128'h0, lat);
        check_eq("err_after_reset", 128'(mem_err), 128'd0);

`ifdef MEM_JITTER_EN
        for (int i = 0; i < 64; i++) begin
            txn(1'b1, 1'b0, 28'h10, 128'h0, lat);
        end
        check_eq("jitter_all_seen", 128'(jit_seen), 128'hF);
`endif

        check_eq("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
